exc_redirect_ctrl: RTL and testbench

//  Exception/ERET commit sequencer between the WB stage and instruction fetch.

---
 rtl/exc_redirect_ctrl.sv | 140 ++++++++++++++
 tb/tb_exc_redirect_ctrl.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exc_redirect_ctrl.sv
// exc_redirect_ctrl: exception / ERET commit sequencer between WB and fetch.
// Picks the highest-priority WB event, fires one cancel plus one CP0 commit
// strobe, holds the fetch redirect until accepted, then drains for a fixed
// number of cycles before taking the next event.
// Optional feature macro: EXC_CNT_EN adds a saturating 16-bit exc_count output.
module exc_redirect_ctrl #(
  parameter logic [31:0] EXC_ENTRY    = 32'hbfc00380,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        wb_valid,
  input  logic [31:0] wb_pc,
  input  logic        wb_bd,
  input  logic [6:0]  wb_exc,
  input  logic        wb_ades,
  input  logic        wb_eret,
  input  logic [31:0] cp0_epc,
  input  logic        inst_addr_ok,
  output logic        wb_ready,
  output logic        cancel,
  output logic        exc_commit,
  output logic        eret_commit,
  output logic [4:0]  excode,
  output logic        bd_out,
  output logic [31:0] epc_out,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc
`ifdef EXC_CNT_EN
  ,
  output logic [15:0] exc_count
`endif
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] FLUSH_INIT = CNT_W'(FLUSH_CYCLES);

  // Flag positions inside wb_exc
  localparam int unsigned B_INT     = 6;
  localparam int unsigned B_ADEL_IF = 5;
  localparam int unsigned B_RI      = 4;
  localparam int unsigned B_OV      = 3;
  localparam int unsigned B_SYS     = 2;
  localparam int unsigned B_BRK     = 1;
  localparam int unsigned B_ADE     = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HOLD  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  drain_cnt;
  logic              is_idle;
  logic              any_exc;
  logic              accept;
  logic [4:0]        code_sel;
  logic [31:0]       epc_sel;

  // Event decode and same-cycle commit strobes for the accept cycle
  always_comb begin
    is_idle     = (state == ST_IDLE);
    any_exc     = |wb_exc;
    accept      = is_idle & wb_valid & (any_exc | wb_eret);
    code_sel    = 5'd0;
    epc_sel     = wb_bd ? (wb_pc - 32'd4) : wb_pc;

    if (wb_exc[B_INT])          code_sel = 5'd0;
    else if (wb_exc[B_ADEL_IF]) code_sel = 5'd4;
    else if (wb_exc[B_RI])      code_sel = 5'd10;
    else if (wb_exc[B_OV])      code_sel = 5'd12;
    else if (wb_exc[B_SYS])     code_sel = 5'd8;
    else if (wb_exc[B_BRK])     code_sel = 5'd9;
    else if (wb_exc[B_ADE])     code_sel = wb_ades ? 5'd5 : 5'd4;

    wb_ready    = is_idle;
    cancel      = accept;
    exc_commit  = accept & any_exc;
    eret_commit = accept & ~any_exc;
    excode      = exc_commit ? code_sel : 5'd0;
    bd_out      = exc_commit & wb_bd;
    epc_out     = exc_commit ? epc_sel : 32'd0;
  end

  // Sequencer: latch redirect on accept, hold until fetch takes it, then drain
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state          <= ST_IDLE;
      drain_cnt      <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= 32'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state          <= ST_HOLD;
            redirect_valid <= 1'b1;
            redirect_pc    <= any_exc ? EXC_ENTRY : cp0_epc;
          end
        end
        ST_HOLD: begin
          if (inst_addr_ok) begin
            redirect_valid <= 1'b0;
            if (FLUSH_CYCLES == 0) begin
              state <= ST_IDLE;
            end else begin
              state     <= ST_DRAIN;
              drain_cnt <= FLUSH_INIT;
            end
          end
        end
        ST_DRAIN: begin
          if (drain_cnt <= CNT_W'(1)) begin
            state     <= ST_IDLE;
            drain_cnt <= '0;
          end else begin
            drain_cnt <= drain_cnt - CNT_W'(1);
          end
        end
        default: begin
          state          <= ST_IDLE;
          redirect_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef EXC_CNT_EN
  // Saturating count of committed exceptions (ERET excluded)
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      exc_count <= 16'd0;
    end else if (exc_commit && (exc_count != 16'hffff)) begin
      exc_count <= exc_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_exc_redirect_ctrl.sv
// Bench for exc_redirect_ctrl: directed scenarios plus a randomized run
// checked against a cycle-level reference model of the commit sequencer.
module tb_exc_redirect_ctrl;

  localparam logic [31:0] ENTRY = 32'hbfc00380;
  localparam int          FLUSH = 2;

  logic        clk = 1'b0;
  logic        resetn;
  logic        wb_valid;
  logic [31:0] wb_pc;
  logic        wb_bd;
  logic [6:0]  wb_exc;
  logic        wb_ades;
  logic        wb_eret;
  logic [31:0] cp0_epc;
  logic        inst_addr_ok;
  logic        wb_ready;
  logic        cancel;
  logic        exc_commit;
  logic        eret_commit;
  logic [4:0]  excode;
  logic        bd_out;
  logic [31:0] epc_out;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
`ifdef EXC_CNT_EN
  logic [15:0] exc_count;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  exc_redirect_ctrl #(.EXC_ENTRY(ENTRY), .FLUSH_CYCLES(FLUSH)) dut (
    .clk(clk), .resetn(resetn), .wb_valid(wb_valid), .wb_pc(wb_pc),
    .wb_bd(wb_bd), .wb_exc(wb_exc), .wb_ades(wb_ades), .wb_eret(wb_eret),
    .cp0_epc(cp0_epc), .inst_addr_ok(inst_addr_ok), .wb_ready(wb_ready),
    .cancel(cancel), .exc_commit(exc_commit), .eret_commit(eret_commit),
    .excode(excode), .bd_out(bd_out), .epc_out(epc_out),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
`ifdef EXC_CNT_EN
    , .exc_count(exc_count)
`endif
  );

  always #5 clk = ~clk;

  // Reference ExcCode: first set flag in priority order wins
  function automatic logic [4:0] ref_code(input logic [6:0] e, input logic ades);
    int        order [7];
    logic [4:0] codes [7];
    order = '{6, 5, 4, 3, 2, 1, 0};
    codes = '{5'd0, 5'd4, 5'd10, 5'd12, 5'd8, 5'd9, (ades ? 5'd5 : 5'd4)};
    for (int k = 0; k < 7; k++) begin
      if (e[order[k]]) return codes[k];
    end
    return 5'd0;
  endfunction

  task automatic clear_inputs();
    wb_valid = 1'b0; wb_pc = 32'd0; wb_bd = 1'b0; wb_exc = 7'd0;
    wb_ades = 1'b0; wb_eret = 1'b0; cp0_epc = 32'd0; inst_addr_ok = 1'b0;
  endtask

  // Fetch accepts the pending redirect, then wait out the drain
  task automatic release_redirect();
    inst_addr_ok = 1'b1;
    @(posedge clk); #1;
    inst_addr_ok = 1'b0;
    repeat (FLUSH + 1) @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    clear_inputs();
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    resetn = 1'b0;
    #2;
    n_tests++;
    if (wb_ready !== 1'b1 || redirect_valid !== 1'b0 || cancel !== 1'b0 ||
        exc_commit !== 1'b0 || eret_commit !== 1'b0 || redirect_pc !== 32'd0 ||
        excode !== 5'd0 || bd_out !== 1'b0 || epc_out !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: ready=%b rv=%b cancel=%b ec=%b er=%b rpc=%h code=%0d want ready=1 rest=0",
               wb_ready, redirect_valid, cancel, exc_commit, eret_commit, redirect_pc, excode);
    end
`ifdef EXC_CNT_EN
    n_tests++;
    if (exc_count !== 16'd0) begin
      n_fail++; $display("FAIL reset_count: got %0d want 0", exc_count);
    end
`endif
    @(posedge clk); #1 resetn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_sys();
    wb_valid = 1'b1; wb_exc = 7'b0000100; wb_pc = 32'h80001000; wb_bd = 1'b0;
    #4;
    n_tests++;
    if (cancel !== 1'b1 || exc_commit !== 1'b1 || eret_commit !== 1'b0 ||
        excode !== 5'd8 || epc_out !== 32'h80001000 || bd_out !== 1'b0) begin
      n_fail++;
      $display("FAIL sys_commit: cancel=%b ec=%b er=%b code=%0d epc=%h bd=%b want 1 1 0 8 80001000 0",
               cancel, exc_commit, eret_commit, excode, epc_out, bd_out);
    end
    @(posedge clk); #1;
    clear_inputs();
    #1;
    n_tests++;
    if (redirect_valid !== 1'b1 || redirect_pc !== ENTRY || wb_ready !== 1'b0 || cancel !== 1'b0) begin
      n_fail++;
      $display("FAIL sys_redirect: rv=%b rpc=%h ready=%b cancel=%b want 1 %h 0 0",
               redirect_valid, redirect_pc, wb_ready, cancel, ENTRY);
    end
    release_redirect();
  endtask

  task automatic test_priority();
    wb_valid = 1'b1; wb_exc = 7'b0001010; wb_eret = 1'b1;
    wb_bd = 1'b1; wb_pc = 32'h80000010; cp0_epc = 32'h12345678;
    #4;
    n_tests++;
    if (excode !== 5'd12 || bd_out !== 1'b1 || epc_out !== 32'h8000000c ||
        eret_commit !== 1'b0 || exc_commit !== 1'b1) begin
      n_fail++;
      $display("FAIL priority_ov: code=%0d bd=%b epc=%h er=%b ec=%b want 12 1 8000000c 0 1",
               excode, bd_out, epc_out, eret_commit, exc_commit);
    end
    @(posedge clk); #1;
    clear_inputs();
    n_tests++;
    if (redirect_pc !== ENTRY) begin
      n_fail++; $display("FAIL priority_target: got %h want %h", redirect_pc, ENTRY);
    end
    release_redirect();
  endtask

  task automatic test_eret_hold();
    wb_valid = 1'b1; wb_eret = 1'b1; cp0_epc = 32'h80002000;
    #4;
    n_tests++;
    if (eret_commit !== 1'b1 || exc_commit !== 1'b0 || cancel !== 1'b1) begin
      n_fail++;
      $display("FAIL eret_commit: er=%b ec=%b cancel=%b want 1 0 1", eret_commit, exc_commit, cancel);
    end
    @(posedge clk); #1;
    clear_inputs();
    for (int c = 0; c < 5; c++) begin
      wb_valid = 1'b1; wb_exc = 7'b0000100; cp0_epc = 32'h0badf00d;
      #1;
      n_tests++;
      if (redirect_valid !== 1'b1 || redirect_pc !== 32'h80002000 || cancel !== 1'b0 || exc_commit !== 1'b0) begin
        n_fail++;
        $display("FAIL eret_hold cycle %0d: rv=%b rpc=%h cancel=%b ec=%b want 1 80002000 0 0",
                 c, redirect_valid, redirect_pc, cancel, exc_commit);
      end
      @(posedge clk); #1;
    end
    clear_inputs();
    release_redirect();
  endtask

  task automatic test_drain();
    wb_valid = 1'b1; wb_exc = 7'b0000100; wb_pc = 32'h80003000;
    @(posedge clk); #1;
    clear_inputs();
    inst_addr_ok = 1'b1;               // cycle T
    @(posedge clk); #1;                // T+1
    inst_addr_ok = 1'b0;
    wb_valid = 1'b1; wb_exc = 7'b0000100;
    #1;
    n_tests++;
    if (wb_ready !== 1'b0 || cancel !== 1'b0 || exc_commit !== 1'b0 || redirect_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL drain_t1: ready=%b cancel=%b ec=%b rv=%b want 0 0 0 0", wb_ready, cancel, exc_commit, redirect_valid);
    end
    @(posedge clk); #1;                // T+2
    clear_inputs();
    inst_addr_ok = 1'b1;
    #1;
    n_tests++;
    if (wb_ready !== 1'b0) begin
      n_fail++; $display("FAIL drain_t2: ready=%b want 0", wb_ready);
    end
    @(posedge clk); #1;                // T+3
    inst_addr_ok = 1'b0;
    n_tests++;
    if (wb_ready !== 1'b1 || redirect_valid !== 1'b0) begin
      n_fail++; $display("FAIL drain_t3: ready=%b rv=%b want 1 0", wb_ready, redirect_valid);
    end
    // fetch ack in IDLE must not disturb anything
    inst_addr_ok = 1'b1;
    @(posedge clk); #1;
    inst_addr_ok = 1'b0;
    n_tests++;
    if (wb_ready !== 1'b1 || redirect_valid !== 1'b0) begin
      n_fail++; $display("FAIL idle_ok_ignored: ready=%b rv=%b want 1 0", wb_ready, redirect_valid);
    end
  endtask

  task automatic test_invalid();
    wb_valid = 1'b0; wb_exc = 7'b1111111; wb_eret = 1'b1;
    #1;
    n_tests++;
    if (cancel !== 1'b0 || exc_commit !== 1'b0 || eret_commit !== 1'b0) begin
      n_fail++; $display("FAIL invalid_ignored: cancel=%b ec=%b er=%b want 0 0 0", cancel, exc_commit, eret_commit);
    end
    @(posedge clk); #1;
    clear_inputs();
    n_tests++;
    if (wb_ready !== 1'b1 || redirect_valid !== 1'b0) begin
      n_fail++; $display("FAIL invalid_state: ready=%b rv=%b want 1 0", wb_ready, redirect_valid);
    end
  endtask

  task automatic test_reset_hold();
    wb_valid = 1'b1; wb_eret = 1'b1; cp0_epc = 32'h80004000;
    @(posedge clk); #1;
    clear_inputs();
    n_tests++;
    if (redirect_valid !== 1'b1) begin
      n_fail++; $display("FAIL rst_hold_pre: rv=%b want 1", redirect_valid);
    end
    resetn = 1'b0;
    #1;
    n_tests++;
    if (redirect_valid !== 1'b0 || wb_ready !== 1'b1 || redirect_pc !== 32'd0) begin
      n_fail++;
      $display("FAIL rst_hold_abort: rv=%b ready=%b rpc=%h want 0 1 0", redirect_valid, wb_ready, redirect_pc);
    end
    @(posedge clk); #1 resetn = 1'b1;
    @(posedge clk); #1;
  endtask

  // Randomized run against a reference model of the redirect protocol
  task automatic test_random();
    logic        m_pending;
    int          m_drain;
    logic [31:0] m_pc;
    logic        idle, acc, has_exc;
    logic [31:0] exp_epc;
    int          r;
    apply_reset();
    m_pending = 1'b0; m_drain = 0; m_pc = 32'd0;
    for (int i = 0; i < 400; i++) begin
      wb_valid = ($urandom_range(0, 3) != 0);
      r = $urandom_range(0, 3);
      if (r == 1)      wb_exc = 7'(1 << $urandom_range(0, 6));
      else if (r == 2) wb_exc = 7'($urandom);
      else             wb_exc = 7'd0;
      wb_eret = 1'($urandom);
      wb_ades = 1'($urandom);
      wb_bd   = 1'($urandom);
      wb_pc   = (i % 7 == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      cp0_epc = $urandom;
      inst_addr_ok = ($urandom_range(0, 2) == 0);
      #4;
      idle    = !m_pending && (m_drain == 0);
      has_exc = (wb_exc != 7'd0);
      acc     = idle && wb_valid && (has_exc || wb_eret);
      exp_epc = wb_bd ? wb_pc - 32'd4 : wb_pc;
      n_tests++;
      if (wb_ready !== idle || cancel !== acc || exc_commit !== (acc && has_exc) ||
          eret_commit !== (acc && !has_exc) || redirect_valid !== m_pending) begin
        n_fail++;
        $display("FAIL rnd_ctrl %0d: ready=%b cancel=%b ec=%b er=%b rv=%b want %b %b %b %b %b",
                 i, wb_ready, cancel, exc_commit, eret_commit, redirect_valid,
                 idle, acc, acc && has_exc, acc && !has_exc, m_pending);
      end
      if (acc && has_exc) begin
        n_tests++;
        if (excode !== ref_code(wb_exc, wb_ades) || bd_out !== wb_bd || epc_out !== exp_epc) begin
          n_fail++;
          $display("FAIL rnd_payload %0d: code=%0d bd=%b epc=%h want %0d %b %h",
                   i, excode, bd_out, epc_out, ref_code(wb_exc, wb_ades), wb_bd, exp_epc);
        end
      end
      if (m_pending) begin
        n_tests++;
        if (redirect_pc !== m_pc) begin
          n_fail++; $display("FAIL rnd_target %0d: got %h want %h", i, redirect_pc, m_pc);
        end
      end
      @(posedge clk);
      if (acc) begin
        m_pending = 1'b1;
        m_pc = has_exc ? ENTRY : cp0_epc;
      end else if (m_pending) begin
        if (inst_addr_ok) begin
          m_pending = 1'b0;
          m_drain = FLUSH;
        end
      end else if (m_drain > 0) begin
        m_drain--;
      end
      #1;
    end
    clear_inputs();
  endtask

`ifdef EXC_CNT_EN
  task automatic test_count();
    apply_reset();
    for (int k = 0; k < 4; k++) begin
      wb_valid = 1'b1;
      if (k == 2) wb_eret = 1'b1;
      else        wb_exc  = 7'b0000010;
      @(posedge clk); #1;
      clear_inputs();
      release_redirect();
    end
    n_tests++;
    if (exc_count !== 16'd3) begin
      n_fail++; $display("FAIL exc_count: got %0d want 3", exc_count);
    end
  endtask
`endif

  initial begin
    clear_inputs();
    resetn = 1'b0;
    test_reset();
    test_sys();
    test_priority();
    test_eret_hold();
    test_drain();
    test_invalid();
    test_reset_hold();
    test_random();
`ifdef EXC_CNT_EN
    test_count();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
